// File: rtl/serial_receiver_if.sv
// Bundles the beat input, word output handshake and status/error lines of the
// serial receiver. The master side is the beat source and word consumer; the slave side is the receiver.
interface serial_receiver_if #(
  parameter int N = 1
);
  logic [N-1:0] Din;
  logic         DinValid;
  logic         StartRx;
  logic [31:0]  DataOut;
  logic         DataValid;
  logic         DataReady;
  logic         RxDone;
  logic         RxBusy;
  logic         Overrun;
  logic         FrameErr;
  logic         ClearErr;

  modport master (
    output Din, DinValid, StartRx, DataReady, ClearErr,
    input  DataOut, DataValid, RxDone, RxBusy, Overrun, FrameErr
  );

  modport slave (
    input  Din, DinValid, StartRx, DataReady, ClearErr,
    output DataOut, DataValid, RxDone, RxBusy, Overrun, FrameErr
  );
endinterface

// File: rtl/serial_receiver.sv
// Serial receiver: assembles a 32-bit word from MSB-first N-bit beats.
// A frame opens with StartRx on its first beat. The finished word goes out on a
// valid/ready handshake. The shift register serves as a one-word holding slot
// when the output is stalled (FULL). Overrun and framing errors are sticky.
module serial_receiver #(
  parameter int N = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  serial_receiver_if.slave  rx
);

  localparam int BEATS = 32 / N;
  localparam int CW    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  state_t        state;
  state_t        next_state;
  logic [31:0]   sr;
  logic [CW-1:0] cnt;

  logic [31:0]   shifted;
  logic [31:0]   word_in;
  logic [CW-1:0] cnt_next;
  logic          load_beat;
  logic          shift_beat;
  logic          take_beat;
  logic          complete;
  logic          slot_free;
  logic          deliver_new;
  logic          deliver_held;
  logic          ovr_set;
  logic          ferr_set;

  // A full-width beat replaces the whole register, so there is nothing to shift.
  if (N == 32) begin : g_wide
    assign shifted = rx.Din;
  end else begin : g_narrow
    assign shifted = {sr[31-N:0], rx.Din};
  end

  // StartRx opens a new frame from IDLE or SHIFT. A StartRx in SHIFT throws away the partial word.
  // While FULL, every beat is dropped.
  assign load_beat    = rx.DinValid && rx.StartRx && (state != FULL);
  assign shift_beat   = rx.DinValid && !rx.StartRx && (state == SHIFT);
  assign take_beat    = load_beat || shift_beat;
  assign word_in      = load_beat ? 32'(rx.Din) : shifted;
  assign cnt_next     = load_beat ? CW'(1) : cnt + CW'(1);
  assign complete     = take_beat && (cnt_next == CW'(BEATS));
  assign slot_free    = !rx.DataValid || rx.DataReady;
  assign deliver_new  = complete && slot_free;
  assign deliver_held = (state == FULL) && rx.DataValid && rx.DataReady;
  assign ovr_set      = (state == FULL) && rx.DinValid;
  assign ferr_set     = (state == SHIFT) && rx.DinValid && rx.StartRx;

  // Next-state logic. A word that completes goes to the output if the slot is free, otherwise it is parked in FULL.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, SHIFT: begin
        if (take_beat) begin
          if (!complete)     next_state = SHIFT;
          else if (slot_free) next_state = IDLE;
          else               next_state = FULL;
        end
      end
      FULL: begin
        if (deliver_held) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register. RxBusy is registered with it so the flag tracks the state exactly.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      rx.RxBusy <= 1'b0;
    end else begin
      state     <= next_state;
      rx.RxBusy <= (next_state != IDLE);
    end
  end

  // Shift register and beat counter. The counter returns to 0 when a word completes, so it never wraps.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (take_beat) begin
      sr  <= word_in;
      cnt <= complete ? '0 : cnt_next;
    end
  end

  // Output slot: load a freshly completed word or the parked one. Clear valid once the consumer takes the word.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx.DataOut   <= '0;
      rx.DataValid <= 1'b0;
      rx.RxDone    <= 1'b0;
    end else begin
      rx.RxDone <= deliver_new || deliver_held;
      if (deliver_new) begin
        rx.DataOut   <= word_in;
        rx.DataValid <= 1'b1;
      end else if (deliver_held) begin
        rx.DataOut   <= sr;
        rx.DataValid <= 1'b1;
      end else if (rx.DataValid && rx.DataReady) begin
        rx.DataValid <= 1'b0;
      end
    end
  end

  // Sticky error flags. A new error on the same cycle as ClearErr takes priority over the clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx.Overrun  <= 1'b0;
      rx.FrameErr <= 1'b0;
    end else begin
      if (ovr_set)          rx.Overrun <= 1'b1;
      else if (rx.ClearErr) rx.Overrun <= 1'b0;
      if (ferr_set)         rx.FrameErr <= 1'b1;
      else if (rx.ClearErr) rx.FrameErr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Testbench for serial_receiver. Five receivers are instantiated (N = 1, 2, 4, 8, 32).
// Words are queued as expected results when their stimulus is issued.
// A forked monitor pops and compares a queued word on every accepted output handshake.
module tb_serial_receiver;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  logic [31:0] din [5];
  logic [4:0]  dinValid, startRx, dataReady, clearErr;
  logic [31:0] dout [5];
  logic [4:0]  dv, done, busy, ovr, ferr;

  logic [31:0] expQ [5][$];
  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 5; g++) begin : gen
    localparam int NW = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 32;
    serial_receiver_if #(.N(NW)) bus ();
    serial_receiver #(.N(NW)) dut (.Clk(Clk), .Reset(Reset), .rx(bus.slave));
    assign bus.Din       = din[g][NW-1:0];
    assign bus.DinValid  = dinValid[g];
    assign bus.StartRx   = startRx[g];
    assign bus.DataReady = dataReady[g];
    assign bus.ClearErr  = clearErr[g];
    assign dout[g]       = bus.DataOut;
    assign dv[g]         = bus.DataValid;
    assign done[g]       = bus.RxDone;
    assign busy[g]       = bus.RxBusy;
    assign ovr[g]        = bus.Overrun;
    assign ferr[g]       = bus.FrameErr;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge Clk);
      for (int u = 0; u < 5; u++) begin
        if (!Reset && dv[u] && dataReady[u]) begin
          if (expQ[u].size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_unexpected_u%0d actual=%h required=none", u, dout[u]);
          end else begin
            checkOutput($sformatf("sb_word_u%0d", u), dout[u], expQ[u].pop_front());
          end
        end
      end
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int u, input logic [31:0] beat, input logic start, input logic clr);
    din[u]      = beat;
    dinValid[u] = 1'b1;
    startRx[u]  = start;
    clearErr[u] = clr;
    @(posedge Clk);
    #1;
    dinValid[u] = 1'b0;
    startRx[u]  = 1'b0;
    clearErr[u] = 1'b0;
  endtask

  function automatic logic [31:0] beatOf(input logic [31:0] word, input int n, input int b);
    logic [63:0] w;
    w = {32'b0, word};
    return 32'((w >> (32 - n * (b + 1))) & ((64'd1 << n) - 64'd1));
  endfunction

  task automatic sendWord(input int u, input int n, input logic [31:0] word, input logic clrFirst);
    expQ[u].push_back(word);
    for (int b = 0; b < 32 / n; b++)
      applyStimulus(u, beatOf(word, n, b), b == 0, clrFirst && (b == 0));
  endtask

  initial begin
    int pulses;
    logic [31:0] burst [4];
    burst[0] = 32'h00000000;
    burst[1] = 32'hFFFFFFFF;
    burst[2] = 32'h80000001;
    burst[3] = 32'h13579BDF;
    for (int u = 0; u < 5; u++) din[u] = '0;
    dinValid  = '0;
    startRx   = '0;
    clearErr  = '0;
    dataReady = '1;
    Reset     = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset_dout", dout[3], 32'h0);
    checkOutput("reset_valid", 32'(dv), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_flags", 32'({ovr, ferr}), 32'h0);
    Reset = 1'b0;
    fork
      monitor();
    join_none
    cycles(2);

    // N=1, full word at full rate, exact one-cycle latency
    expQ[0].push_back(32'hA5A50F0F);
    for (int b = 0; b < 32; b++) begin
      applyStimulus(0, beatOf(32'hA5A50F0F, 1, b), b == 0, 1'b0);
      if (b == 30) checkOutput("t1_done_early", 32'(done[0]), 32'h0);
    end
    checkOutput("t1_done", 32'(done[0]), 32'h1);
    checkOutput("t1_valid", 32'(dv[0]), 32'h1);
    checkOutput("t1_dout", dout[0], 32'hA5A50F0F);
    cycles(1);
    checkOutput("t1_done_pulse", 32'(done[0]), 32'h0);
    cycles(2);

    // N=8, gaps of three idle cycles between beats
    pulses = 0;
    expQ[3].push_back(32'hDEADBEEF);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(3, beatOf(32'hDEADBEEF, 8, b), b == 0, 1'b0);
      if (done[3]) pulses++;
      if (b < 3) begin
        checkOutput("t2_busy_beat", 32'(busy[3]), 32'h1);
        repeat (3) begin
          cycles(1);
          checkOutput("t2_busy_gap", 32'(busy[3]), 32'h1);
          if (done[3]) pulses++;
        end
      end
    end
    checkOutput("t2_done", 32'(done[3]), 32'h1);
    checkOutput("t2_busy_end", 32'(busy[3]), 32'h0);
    checkOutput("t2_dout", dout[3], 32'hDEADBEEF);
    cycles(2);
    if (done[3]) pulses++;
    checkOutput("t2_pulses", 32'(pulses), 32'h1);

    // N=8, stalled consumer: FULL, overrun, then in-order drain
    dataReady[3] = 1'b0;
    sendWord(3, 8, 32'h11223344, 1'b0);
    sendWord(3, 8, 32'h55667788, 1'b0);
    checkOutput("t3_busy_full", 32'(busy[3]), 32'h1);
    checkOutput("t3_dout_hold", dout[3], 32'h11223344);
    checkOutput("t3_ovr_before", 32'(ovr[3]), 32'h0);
    applyStimulus(3, 32'hAB, 1'b0, 1'b0);
    checkOutput("t3_ovr", 32'(ovr[3]), 32'h1);
    checkOutput("t3_busy_ovr", 32'(busy[3]), 32'h1);
    dataReady[3] = 1'b1;
    cycles(1);
    checkOutput("t3_done_accept", 32'(done[3]), 32'h1);
    checkOutput("t3_dout_second", dout[3], 32'h55667788);
    checkOutput("t3_busy_idle", 32'(busy[3]), 32'h0);
    cycles(1);
    checkOutput("t3_valid_drop", 32'(dv[3]), 32'h0);
    clearErr[3] = 1'b1;
    cycles(1);
    clearErr[3] = 1'b0;
    checkOutput("t3_ovr_clear", 32'(ovr[3]), 32'h0);

    // N=4, StartRx mid-frame, clear, then clear colliding with a new error
    applyStimulus(2, 32'h1, 1'b1, 1'b0);
    applyStimulus(2, 32'h2, 1'b0, 1'b0);
    applyStimulus(2, 32'h3, 1'b0, 1'b0);
    checkOutput("t4_ferr_before", 32'(ferr[2]), 32'h0);
    sendWord(2, 4, 32'hCAFEF00D, 1'b0);
    checkOutput("t4_ferr", 32'(ferr[2]), 32'h1);
    checkOutput("t4_done", 32'(done[2]), 32'h1);
    checkOutput("t4_dout", dout[2], 32'hCAFEF00D);
    clearErr[2] = 1'b1;
    cycles(1);
    clearErr[2] = 1'b0;
    checkOutput("t4_ferr_clear", 32'(ferr[2]), 32'h0);
    applyStimulus(2, 32'h8, 1'b1, 1'b0);
    sendWord(2, 4, 32'h89ABCDEF, 1'b1);
    checkOutput("t4_ferr_wins", 32'(ferr[2]), 32'h1);
    cycles(2);

    // N=2, asynchronous reset in the middle of a frame
    for (int b = 0; b < 7; b++)
      applyStimulus(1, beatOf(32'hFFFFFFFF, 2, b), b == 0, 1'b0);
    checkOutput("t5_busy_mid", 32'(busy[1]), 32'h1);
    din[1] = 32'h3;
    dinValid[1] = 1'b1;
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("t5_busy_async", 32'(busy[1]), 32'h0);
    checkOutput("t5_ferr_async", 32'(ferr[2]), 32'h0);
    checkOutput("t5_dout_async", dout[3], 32'h0);
    checkOutput("t5_valid_async", 32'(dv), 32'h0);
    @(posedge Clk);
    #1;
    dinValid[1] = 1'b0;
    Reset = 1'b0;
    checkOutput("t5_busy_after", 32'(busy[1]), 32'h0);
    sendWord(1, 2, 32'h0BADC0DE, 1'b0);
    checkOutput("t5_done", 32'(done[1]), 32'h1);
    checkOutput("t5_dout", dout[1], 32'h0BADC0DE);
    cycles(2);

    // N=32, single-beat frames back to back
    expQ[4].push_back(32'h12345678);
    applyStimulus(4, 32'h12345678, 1'b1, 1'b0);
    checkOutput("t6_dout", dout[4], 32'h12345678);
    checkOutput("t6_done", 32'(done[4]), 32'h1);
    for (int i = 0; i < 4; i++) begin
      expQ[4].push_back(burst[i]);
      applyStimulus(4, burst[i], 1'b1, 1'b0);
      checkOutput($sformatf("t6_burst_done%0d", i), 32'(done[4]), 32'h1);
      checkOutput($sformatf("t6_burst_dout%0d", i), dout[4], burst[i]);
    end
    cycles(1);
    checkOutput("t6_done_end", 32'(done[4]), 32'h0);
    checkOutput("t6_valid_end", 32'(dv[4]), 32'h0);

    cycles(3);
    for (int u = 0; u < 5; u++)
      checkOutput($sformatf("sb_drained_u%0d", u), 32'(expQ[u].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
